// File: rtl/vx_alu_commit_sink.sv
// Commit sink for the ALU unit: buffers register-writing commit beats in order,
// drives the regfile writeback port from the FIFO head and counts retired instructions.
module vx_alu_commit_sink #(
  parameter int CORE_ID     = 0,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 6,
  parameter int UUID_BITS   = 44,
  parameter int DEPTH       = 2
) (
  input  logic                      clk,
  input  logic                      reset,

  // Handshake: a beat transfers on any rising edge where valid && ready; ready
  // never looks at valid, and writeback_ready only affects the next cycle.
  input  logic                      commit_valid,
  input  logic [UUID_BITS-1:0]      commit_uuid,
  input  logic [NW_BITS-1:0]        commit_wid,
  input  logic [NUM_THREADS-1:0]    commit_tmask,
  input  logic [31:0]               commit_PC,
  input  logic [NR_BITS-1:0]        commit_rd,
  input  logic                      commit_wb,
  input  logic [NUM_THREADS*32-1:0] commit_data,
  input  logic                      commit_eop,
  output logic                      commit_ready,

  output logic                      writeback_valid,
  output logic [NW_BITS-1:0]        writeback_wid,
  output logic [NUM_THREADS-1:0]    writeback_tmask,
  output logic [NR_BITS-1:0]        writeback_rd,
  output logic [NUM_THREADS*32-1:0] writeback_data,
  output logic [31:0]               writeback_PC,
  input  logic                      writeback_ready,

  output logic [63:0]               instret,
  output logic [31:0]               wb_stall_cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = NUM_THREADS * 32;
  localparam logic [31:0] CORE_ID_W = CORE_ID;

  typedef struct packed {
    logic [NW_BITS-1:0]     wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [NR_BITS-1:0]     rd;
    logic [DW-1:0]          data;
    logic [31:0]            pc;
    logic                   eop;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head;
  entry_t          push_entry;

  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [63:0]     instret_q, instret_d;
  logic [31:0]     stall_q, stall_d;

  logic            full;
  logic            empty;
  logic            accept;
  logic            is_wr;
  logic            push;
  logic            pop;
  logic            drop_eop;
  logic            pop_eop;

  // uuid and core id only matter for tracing
  logic            unused_trace;
  assign unused_trace = ^{commit_uuid, CORE_ID_W};

  // The extra pointer MSB tells a full ring apart from an empty one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign commit_ready = !full;
  assign accept       = commit_valid && commit_ready;
  assign is_wr        = commit_wb && (commit_rd != '0);
  assign push         = accept && is_wr;
  assign pop          = !empty && writeback_ready;
  assign drop_eop     = accept && !is_wr && commit_eop;

  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_eop = pop && head.eop;

  always_comb begin
    push_entry       = '0;
    push_entry.wid   = commit_wid;
    push_entry.tmask = commit_tmask;
    push_entry.rd    = commit_rd;
    push_entry.data  = commit_data;
    push_entry.pc    = commit_PC;
    push_entry.eop   = commit_eop;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    instret_d = instret_q + {63'd0, drop_eop} + {63'd0, pop_eop};
    stall_d   = stall_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (!empty && !writeback_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      instret_q <= '0;
      stall_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      instret_q <= instret_d;
      stall_q   <= stall_d;
    end
  end

  // Storage needs no reset: pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
    end
  end

  assign writeback_valid = !empty;
  assign writeback_wid   = head.wid;
  assign writeback_tmask = head.tmask;
  assign writeback_rd    = head.rd;
  assign writeback_data  = head.data;
  assign writeback_PC    = head.pc;

  assign instret         = instret_q;
  assign wb_stall_cycles = stall_q;

endmodule

// File: tb/tb_vx_alu_commit_sink.sv
// Randomised and directed bench for vx_alu_commit_sink with a queue-based
// reference model; a negedge monitor compares every cycle.
module tb_vx_alu_commit_sink;

  localparam int DEPTH = 2;
  localparam int EW    = 2 + 4 + 6 + 128 + 32 + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         commit_valid = 1'b0;
  logic [43:0]  commit_uuid = '0;
  logic [1:0]   commit_wid = '0;
  logic [3:0]   commit_tmask = '0;
  logic [31:0]  commit_PC = '0;
  logic [5:0]   commit_rd = '0;
  logic         commit_wb = 1'b0;
  logic [127:0] commit_data = '0;
  logic         commit_eop = 1'b0;
  logic         commit_ready;
  logic         writeback_valid;
  logic [1:0]   writeback_wid;
  logic [3:0]   writeback_tmask;
  logic [5:0]   writeback_rd;
  logic [127:0] writeback_data;
  logic [31:0]  writeback_PC;
  logic         writeback_ready = 1'b1;
  logic [63:0]  instret;
  logic [31:0]  wb_stall_cycles;

  int n_vec = 0;
  int n_err = 0;
  int ready_mode = 1;

  logic [EW-1:0] exp_q[$];
  logic [63:0]   exp_instret = '0;
  logic [31:0]   exp_stall = '0;

  vx_alu_commit_sink #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_uuid(commit_uuid), .commit_wid(commit_wid),
    .commit_tmask(commit_tmask), .commit_PC(commit_PC), .commit_rd(commit_rd),
    .commit_wb(commit_wb), .commit_data(commit_data), .commit_eop(commit_eop),
    .commit_ready(commit_ready),
    .writeback_valid(writeback_valid), .writeback_wid(writeback_wid),
    .writeback_tmask(writeback_tmask), .writeback_rd(writeback_rd),
    .writeback_data(writeback_data), .writeback_PC(writeback_PC),
    .writeback_ready(writeback_ready),
    .instret(instret), .wb_stall_cycles(wb_stall_cycles)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       writeback_ready = 1'b0;
      1:       writeback_ready = 1'b1;
      default: writeback_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] wid, input logic [3:0] tmask, input logic [5:0] rd,
                      input logic [127:0] data, input logic [31:0] pc,
                      input logic wb, input logic eop);
    logic acc;
    int   t;
    commit_valid = 1'b1;
    commit_uuid  = 44'($urandom);
    commit_wid   = wid;
    commit_tmask = tmask;
    commit_rd    = rd;
    commit_data  = data;
    commit_PC    = pc;
    commit_wb    = wb;
    commit_eop   = eop;
    t = 0;
    forever begin
      @(negedge clk);
      acc = commit_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout: beat rd=%0d not accepted within 200 cycles", rd);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    commit_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [EW-1:0] e;
    int occ;
    @(posedge clk);
    forever begin
      @(negedge clk);
      occ = exp_q.size();
      check("commit_ready", {191'd0, commit_ready}, {191'd0, occ < DEPTH});
      check("writeback_valid", {191'd0, writeback_valid}, {191'd0, occ != 0});
      check("instret", {128'd0, instret}, {128'd0, exp_instret});
      check("wb_stall_cycles", {160'd0, wb_stall_cycles}, {160'd0, exp_stall});
      if (reset) begin
        exp_q.delete();
        exp_instret = '0;
        exp_stall   = '0;
      end else begin
        if (occ != 0 && writeback_ready) begin
          e = exp_q.pop_front();
          check("wb_wid",   {190'd0, writeback_wid},   {190'd0, e[172:171]});
          check("wb_tmask", {188'd0, writeback_tmask}, {188'd0, e[170:167]});
          check("wb_rd",    {186'd0, writeback_rd},    {186'd0, e[166:161]});
          check("wb_data",  {64'd0, writeback_data},   {64'd0, e[160:33]});
          check("wb_pc",    {160'd0, writeback_PC},    {160'd0, e[32:1]});
          if (e[0]) exp_instret = exp_instret + 64'd1;
        end else if (occ != 0) begin
          if (exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
        end
        if (commit_valid && occ < DEPTH) begin
          if (commit_wb && commit_rd != 6'd0)
            exp_q.push_back({commit_wid, commit_tmask, commit_rd, commit_data, commit_PC, commit_eop});
          else if (commit_eop)
            exp_instret = exp_instret + 64'd1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    // single beat
    send(2'd1, 4'b1011, 6'd5, {32'h44, 32'h33, 32'h22, 32'h11}, 32'h8000_0000, 1'b1, 1'b1);
    idle(3);

    // back-to-back rd=1..8
    for (int i = 1; i <= 8; i++)
      send(2'(i), 4'hF, 6'(i), rand_data(), 32'h100 + 32'(i * 4), 1'b1, 1'b1);
    idle(3);

    // back-pressure: third beat waits until release
    ready_mode = 0;
    idle(1);
    send(2'd0, 4'h1, 6'd10, rand_data(), 32'h200, 1'b1, 1'b1);
    send(2'd0, 4'h3, 6'd11, rand_data(), 32'h204, 1'b1, 1'b1);
    fork
      send(2'd0, 4'h7, 6'd12, rand_data(), 32'h208, 1'b1, 1'b1);
      begin repeat (5) @(posedge clk); ready_mode = 1; end
    join
    idle(3);

    // dropped beats interleaved; drop accepted while a pop happens
    send(2'd2, 4'hF, 6'd20, rand_data(), 32'h300, 1'b1, 1'b1);
    send(2'd2, 4'hF, 6'd21, rand_data(), 32'h304, 1'b0, 1'b1);
    send(2'd2, 4'hF, 6'd0,  rand_data(), 32'h308, 1'b1, 1'b1);
    send(2'd2, 4'hF, 6'd22, rand_data(), 32'h30C, 1'b1, 1'b1);
    idle(3);

    // multi-beat instruction
    send(2'd3, 4'h5, 6'd30, rand_data(), 32'h400, 1'b1, 1'b0);
    send(2'd3, 4'hA, 6'd30, rand_data(), 32'h400, 1'b1, 1'b1);
    idle(3);

    // reset while full and stalled
    ready_mode = 0;
    idle(1);
    send(2'd1, 4'hF, 6'd40, rand_data(), 32'h500, 1'b1, 1'b1);
    send(2'd1, 4'hF, 6'd41, rand_data(), 32'h504, 1'b1, 1'b1);
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    ready_mode = 1;
    idle(2);

    // randomised traffic
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send(2'($urandom), 4'($urandom), 6'($urandom_range(0, 7)), rand_data(), $urandom,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    // drain
    ready_mode = 1;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d entries left in expected queue", exp_q.size());
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
